ripple_carry_adder: RTL and testbench

RIPPLE_CARRY_ADDER -- requirements
Module: ripple_carry_adder

---
 rtl/ripple_carry_adder_pkg.sv | 13 +
 rtl/ripple_carry_adder_full_adder.sv | 16 +
 rtl/ripple_carry_adder.sv | 62 ++++++
 tb/tb_ripple_carry_adder.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/ripple_carry_adder_pkg.sv
// Shared constants and result type for the ripple-carry adder.
// RCA_OVF_EN (defined by the consumer) enables the registered signed-overflow output.
package rca_pkg;

    localparam int RCA_DEFAULT_WIDTH = 4;
    localparam int RCA_MAX_WIDTH     = 64;

    // {carry, sum} for the default width; wider instances size their own vector.
    typedef logic [RCA_DEFAULT_WIDTH:0] rca_result_t;

    typedef logic [RCA_MAX_WIDTH:0] rca_wide_result_t;

endpackage

// File: rtl/ripple_carry_adder_full_adder.sv
// One-bit full-adder cell, purely combinational.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic p;

    assign p  = a ^ b;
    assign s  = p ^ ci;
    assign co = (a & b) | (ci & p);

endmodule

// File: rtl/ripple_carry_adder.sv
// Registered WIDTH-bit ripple-carry adder with carry out (1-cycle latency).
// Defining RCA_OVF_EN adds the registered two's-complement overflow output ovf.
module ripple_carry_adder
    import rca_pkg::*;
#(
    parameter int WIDTH = RCA_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef RCA_OVF_EN
    ,
    output logic             ovf
`endif
);

    // Stage p0: combinational ripple chain, carry_p0[i] is the carry into bit i
    logic [WIDTH:0]   carry_p0;
    logic [WIDTH-1:0] sum_p0;

    assign carry_p0[0] = 1'b0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        full_adder u_fa (
            .a  (in1[i]),
            .b  (in2[i]),
            .ci (carry_p0[i]),
            .s  (sum_p0[i]),
            .co (carry_p0[i+1])
        );
    end

    // Stage p1: output register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum  <= '0;
            cout <= 1'b0;
        end else begin
            sum  <= sum_p0;
            cout <= carry_p0[WIDTH];
        end
    end

`ifdef RCA_OVF_EN
    // Signed overflow: carry into the MSB disagrees with carry out of it.
    logic ovf_p0;

    assign ovf_p0 = carry_p0[WIDTH-1] ^ carry_p0[WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf <= 1'b0;
        end else begin
            ovf <= ovf_p0;
        end
    end
`endif

endmodule

// File: tb/tb_ripple_carry_adder.sv
// Scoreboard bench for ripple_carry_adder; checks ovf when RCA_OVF_EN is defined.
module tb_ripple_carry_adder;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] in1;
    logic [W-1:0] in2;
    logic [W-1:0] sum;
    logic         cout;
`ifdef RCA_OVF_EN
    logic         ovf;
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [W:0] res;
        logic       ov;
    } exp_t;

    exp_t sb[$];

    ripple_carry_adder #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst  (rst),
        .in1  (in1),
        .in2  (in2),
        .sum  (sum),
        .cout (cout)
`ifdef RCA_OVF_EN
        ,
        .ovf  (ovf)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        e.res = {1'b0, a} + {1'b0, b};
        e.ov  = (a[W-1] == b[W-1]) && (e.res[W-1] != a[W-1]);
        return e;
    endfunction

    task automatic apply(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        in1 = a;
        in2 = b;
        sb.push_back(model(a, b));
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in1 = 4'b0101;
        in2 = 4'b1000;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({cout, sum} !== 5'b0) begin
                failures++;
                $display("FAIL reset_hold cyc=%0d got=%b required=00000", i, {cout, sum});
            end
`ifdef RCA_OVF_EN
            checks++;
            if (ovf !== 1'b0) begin
                failures++;
                $display("FAIL reset_ovf cyc=%0d got=%b required=0", i, ovf);
            end
`endif
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [W-1:0] ta[2] = '{4'b0001, 4'b0100};
        logic [W-1:0] tb[2] = '{4'b0000, 4'b1011};
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            apply(ta[i], tb[i]);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            checks++;
            if ({cout, sum} !== e.res) begin
                failures++;
                $display("FAIL directed_%0d got=%b required=%b", i, {cout, sum}, e.res);
            end
        end
    endtask

    task automatic test_carry();
        logic [W-1:0] ta[6] = '{4'b1111, 4'b0111, 4'b1111, 4'b1111, 4'b0000, 4'b0111};
        logic [W-1:0] tb[6] = '{4'b0110, 4'b1001, 4'b0001, 4'b1111, 4'b0000, 4'b0001};
        exp_t e;
        for (int i = 0; i < 6; i++) begin
            apply(ta[i], tb[i]);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            checks++;
            if ({cout, sum} !== e.res) begin
                failures++;
                $display("FAIL carry_%0d got=%b required=%b", i, {cout, sum}, e.res);
            end
`ifdef RCA_OVF_EN
            checks++;
            if (ovf !== e.ov) begin
                failures++;
                $display("FAIL carry_ovf_%0d got=%b required=%b", i, ovf, e.ov);
            end
`endif
        end
    endtask

    task automatic test_latency();
        exp_t e;
        apply(4'b0010, 4'b0011);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        // New operands mid-cycle must not show up until the next rising edge.
        apply(4'b1001, 4'b1000);
        #2;
        in1 = 4'b1010;
        in2 = 4'b0100;
        sb[0] = model(4'b1010, 4'b0100);
        #1;
        checks++;
        if ({cout, sum} !== e.res) begin
            failures++;
            $display("FAIL latency_hold got=%b required=%b", {cout, sum}, e.res);
        end
        @(posedge clk);
        #1;
        e = sb.pop_front();
        checks++;
        if ({cout, sum} !== e.res) begin
            failures++;
            $display("FAIL latency_update got=%b required=%b", {cout, sum}, e.res);
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        apply(4'b1111, 4'b0110);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        checks++;
        if ({cout, sum} !== e.res) begin
            failures++;
            $display("FAIL pre_reset got=%b required=%b", {cout, sum}, e.res);
        end
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if ({cout, sum} !== 5'b0) begin
            failures++;
            $display("FAIL async_reset got=%b required=00000", {cout, sum});
        end
        @(negedge clk);
        in1 = 4'b0011;
        in2 = 4'b0100;
        rst = 1'b0;
        sb.push_back(model(4'b0011, 4'b0100));
        @(posedge clk);
        #1;
        e = sb.pop_front();
        checks++;
        if ({cout, sum} !== e.res) begin
            failures++;
            $display("FAIL first_after_reset got=%b required=%b", {cout, sum}, e.res);
        end
    endtask

    task automatic test_exhaustive();
        exp_t e;
        int   bad = 0;
        for (int a = 0; a < (1 << W); a++) begin
            for (int b = 0; b < (1 << W); b++) begin
                apply(W'(a), W'(b));
                @(posedge clk);
                #1;
                e = sb.pop_front();
                checks++;
                if ({cout, sum} !== e.res) begin
                    failures++;
                    if (bad < 8)
                        $display("FAIL exhaustive a=%0d b=%0d got=%b required=%b", a, b, {cout, sum}, e.res);
                    bad++;
                end
`ifdef RCA_OVF_EN
                checks++;
                if (ovf !== e.ov) begin
                    failures++;
                    if (bad < 8)
                        $display("FAIL exhaustive_ovf a=%0d b=%0d got=%b required=%b", a, b, ovf, e.ov);
                    bad++;
                end
`endif
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        in1 = '0;
        in2 = '0;
        test_reset();
        test_directed();
        test_carry();
        test_latency();
        test_async_reset();
        test_exhaustive();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
